regfile_mp: RTL

- Parametrised multi-port integer register file. Successor of the single-write/dual-read core register file, sized for a dual-issue pipeline.
- Provides NRD combinational read ports and NWR clocked write ports, with a write-to-read bypass.
- Includes a per-register busy scoreboard: set at issue, cleared at writeback. Decode uses it for hazard stalls.
- x0 is hardwired to zero. Asynchronous clear of all state.

---
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_mp.sv | 94 +++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Register file port bundle: read ports, write ports, issue and scoreboard view.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]      wclr;
    logic                iss_valid;
    logic [AW-1:0]       iss_a;
    logic [NREGS-1:0]    busy_vec;

    // Pipeline side: drives addresses, write data and issue
    modport master (
        output ra, we, wa, wd, wclr, iss_valid, iss_a,
        input  rd, rbusy, busy_vec
    );

    // Register file side
    modport slave (
        input  ra, we, wa, wd, wclr, iss_valid, iss_a,
        output rd, rbusy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
// x0 reads as zero and is never busy; all state clears asynchronously on rst_n low.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    busy_nxt;
    logic [NRD*XLEN-1:0] rd_c;
    logic [NRD-1:0]      rbusy_c;

    // Register writes; later ports overwrite earlier ones so the highest index wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (bus.we[j] && (bus.wa[j*AW +: AW] != '0)) begin
                    regs[bus.wa[j*AW +: AW]] <= bus.wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears first, then issue sets (new producer wins)
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < int'(NWR); j++) begin
            if (bus.we[j] && bus.wclr[j]) begin
                busy_nxt[bus.wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus.iss_valid) begin
            busy_nxt[bus.iss_a] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Combinational read ports with bypass of same-cycle writes and clears
    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] data;
        logic            bsy;
        rd_c    = '0;
        rbusy_c = '0;
        a       = '0;
        data    = '0;
        bsy     = 1'b0;
        for (int i = 0; i < int'(NRD); i++) begin
            a    = bus.ra[i*AW +: AW];
            data = regs[a];
            bsy  = busy[a];
            for (int j = 0; j < int'(NWR); j++) begin
                if (bus.we[j] && (bus.wa[j*AW +: AW] == a)) begin
                    data = bus.wd[j*XLEN +: XLEN];
                    if (bus.wclr[j]) begin
                        bsy = 1'b0;
                    end
                end
            end
            // x0 and reset both force the zero / not-busy view
            if ((a == '0) || !rst_n) begin
                data = '0;
                bsy  = 1'b0;
            end
            rd_c[i*XLEN +: XLEN] = data;
            rbusy_c[i]           = bsy;
        end
    end

    assign bus.rd       = rd_c;
    assign bus.rbusy    = rbusy_c;
    assign bus.busy_vec = busy;
endmodule
